// File: rtl/alu_pkg.sv
// Shared op codes, status bit positions and FSM encodings for the sequential ALU.
package alu_pkg;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] CMP = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] NOT = 3'b011;
    localparam logic [2:0] MUL = 3'b100;

    localparam int Z_IDX = 2;
    localparam int V_IDX = 1;
    localparam int N_IDX = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    function automatic logic [2:0] pack_flags(input logic z, input logic v, input logic n);
        logic [2:0] f;
        f = '0;
        f[Z_IDX] = z;
        f[V_IDX] = v;
        f[N_IDX] = n;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Start/busy/done request bus between the controller and the sequential ALU.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       ALUop;
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic [2:0]       status;

    modport master (
        output start, ALUop, Ain, Bin,
        input  busy, done, out, status
    );

    modport slave (
        input  start, ALUop, Ain, Bin,
        output busy, done, out, status
    );
endinterface

// File: rtl/alu_addsub_n.sv
// WIDTH-bit adder/subtractor with carry out and two's-complement overflow.
module alu_addsub_n #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic             carry_msb;

    assign b_eff   = sub ? ~b : b;
    assign sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    assign result  = sum_ext[WIDTH-1:0];
    assign cout    = sum_ext[WIDTH];
    // Carry into the MSB recovered from the MSB sum bit.
    assign carry_msb = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ result[WIDTH-1];
    assign ovf       = carry_msb ^ cout;
endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle ADD/CMP/AND/NOT plus a WIDTH-cycle shift-add MUL
// that reuses the operand adder on the upper half of the accumulator.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter bit STATUS_ALL = 1'b0
) (
    input logic      clk,
    input logic      reset,
    alu_seq_if.slave bus
);
    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic [2*WIDTH-1:0] acc, acc_step;
    logic [WIDTH-1:0] mcand, out_r, add_a, add_b, add_sum, op_result;
    logic [CW-1:0]    count;
    logic [2:0]       status_r, op_flags, mul_flags;
    logic             done_r, add_sub, add_cout, add_ovf, op_ovf;
    logic             accept, op_writes_status;

    alu_addsub_n #(.WIDTH(WIDTH)) u_addsub (
        .a      (add_a),
        .b      (add_b),
        .sub    (add_sub),
        .result (add_sum),
        .cout   (add_cout),
        .ovf    (add_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.start && bus.ALUop == MUL) state_next = ST_MUL;
            ST_MUL:  if (count == LAST) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // While multiplying, the adder accumulates into the high half and the
    // multiplier bits are consumed from the low half as acc shifts right.
    always_comb begin
        bus.busy = (state == ST_MUL);
        accept   = (state == ST_IDLE) && bus.start;
        add_a    = bus.Ain;
        add_b    = bus.Bin;
        add_sub  = (bus.ALUop == CMP);
        if (state == ST_MUL) begin
            add_a   = acc[2*WIDTH-1:WIDTH];
            add_b   = acc[0] ? mcand : '0;
            add_sub = 1'b0;
        end
    end

    assign acc_step = {add_cout, add_sum, acc[WIDTH-1:1]};

    always_comb begin
        op_result = '0;
        op_ovf    = 1'b0;
        case (bus.ALUop)
            ADD, CMP: begin
                op_result = add_sum;
                op_ovf    = add_ovf;
            end
            AND:     op_result = bus.Ain & bus.Bin;
            NOT:     op_result = ~bus.Bin;
            default: op_result = '0;
        endcase
        op_flags         = pack_flags(op_result == '0, op_ovf, op_result[WIDTH-1]);
        op_writes_status = STATUS_ALL ? (bus.ALUop <= NOT) : (bus.ALUop == CMP);
        mul_flags        = pack_flags(acc_step[WIDTH-1:0] == '0,
                                      |acc_step[2*WIDTH-1:WIDTH],
                                      acc_step[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_r    <= '0;
            status_r <= '0;
            done_r   <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            count    <= '0;
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                if (bus.ALUop == MUL) begin
                    mcand <= bus.Ain;
                    acc   <= {{WIDTH{1'b0}}, bus.Bin};
                    count <= '0;
                end else begin
                    out_r  <= op_result;
                    done_r <= 1'b1;
                    if (op_writes_status) status_r <= op_flags;
                end
            end else if (state == ST_MUL) begin
                acc   <= acc_step;
                count <= count + 1'b1;
                if (count == LAST) begin
                    out_r  <= acc_step[WIDTH-1:0];
                    done_r <= 1'b1;
                    if (STATUS_ALL) status_r <= mul_flags;
                end
            end
        end
    end

    assign bus.done   = done_r;
    assign bus.out    = out_r;
    assign bus.status = status_r;
endmodule
